paddle_tracker: RTL

Multi-player paddle position tracker for the pong datapath. Each channel takes a 3-bit position-sensor pattern and debounces it. Accepted transitions step a saturating paddle position left or right. Per-cycle step strobes and a sticky sequence-error flag feed the renderer and the score/attract logic; positions drive the paddle renderer directly.

---
 rtl/paddle_tracker_if.sv | 23 ++
 rtl/paddle_tracker.sv | 122 ++++++++++++
 2 files changed

// File: rtl/paddle_tracker_if.sv
// Paddle tracker bus: play enable and sensor patterns in,
// paddle positions, step strobes and error flags out.
interface paddle_tracker_if #(
  parameter int PLAYERS = 2,
  parameter int POS_W   = 3
);
  logic                     en;
  logic [3*PLAYERS-1:0]     sens;
  logic [POS_W*PLAYERS-1:0] pos;
  logic [PLAYERS-1:0]       step_l;
  logic [PLAYERS-1:0]       step_r;
  logic [PLAYERS-1:0]       err;

  modport master (
    output en, sens,
    input  pos, step_l, step_r, err
  );

  modport slave (
    input  en, sens,
    output pos, step_l, step_r, err
  );
endinterface

// File: rtl/paddle_tracker.sv
// Per-player sensor debounce and saturating paddle position.
// Accepted sensor transitions step the paddle; skips flag err.
module paddle_tracker #(
  parameter int PLAYERS  = 2,
  parameter int POS_W    = 3,
  parameter int POS_MAX  = 6,
  parameter int START    = 3,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  paddle_tracker_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE - 1);
  localparam logic [POS_W-1:0] PSTART = POS_W'(START);
  localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);
  localparam logic [2:0] P_L = 3'b100;
  localparam logic [2:0] P_C = 3'b010;
  localparam logic [2:0] P_R = 3'b001;

  logic [2:0]       samp  [PLAYERS];
  logic [2:0]       cand  [PLAYERS];
  logic [2:0]       stab  [PLAYERS];
  logic [CW-1:0]    cnt   [PLAYERS];
  logic [POS_W-1:0] pos_q [PLAYERS];
  logic [PLAYERS-1:0] sl_q;
  logic [PLAYERS-1:0] sr_q;
  logic [PLAYERS-1:0] err_q;

  logic [PLAYERS-1:0] acc;
  logic [PLAYERS-1:0] mv_l;
  logic [PLAYERS-1:0] mv_r;
  logic [PLAYERS-1:0] skip;

  function automatic logic legal(input logic [2:0] v);
    return (v == P_L) || (v == P_C) || (v == P_R);
  endfunction

  // Acceptance happens on the edge where cnt reaches DEBOUNCE.
  always_comb begin
    acc  = '0;
    mv_l = '0;
    mv_r = '0;
    skip = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      acc[p] = (samp[p] == cand[p]) && (cnt[p] == CLAST)
             && (cand[p] != stab[p]) && legal(cand[p]);
      mv_l[p] = acc[p] && (stab[p] == P_L)
              && (cand[p] == P_C);
      mv_r[p] = acc[p] && (stab[p] == P_R)
              && (cand[p] == P_C);
      skip[p] = acc[p]
              && (((stab[p] == P_L) && (cand[p] == P_R))
               || ((stab[p] == P_R) && (cand[p] == P_L)));
    end
  end

  // Debounce, accepted-pattern tracking and paddle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PLAYERS; p++) begin
        samp[p]  <= P_C;
        cand[p]  <= P_C;
        stab[p]  <= P_C;
        cnt[p]   <= '0;
        pos_q[p] <= PSTART;
      end
      sl_q  <= '0;
      sr_q  <= '0;
      err_q <= '0;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        samp[p] <= bus.sens[3*p +: 3];
        if (samp[p] != cand[p]) begin
          cand[p] <= samp[p];
          cnt[p]  <= '0;
        end else if (cnt[p] != CMAX) begin
          cnt[p] <= cnt[p] + CW'(1);
        end
        if (acc[p]) begin
          stab[p] <= cand[p];
        end
        sl_q[p] <= 1'b0;
        sr_q[p] <= 1'b0;
        if (!bus.en) begin
          pos_q[p] <= PSTART;
        end else begin
          unique case (1'b1)
            mv_l[p]: begin
              if (pos_q[p] != '0) begin
                pos_q[p] <= pos_q[p] - POS_W'(1);
                sl_q[p]  <= 1'b1;
              end
            end
            mv_r[p]: begin
              if (pos_q[p] != PMAX) begin
                pos_q[p] <= pos_q[p] + POS_W'(1);
                sr_q[p]  <= 1'b1;
              end
            end
            skip[p]: err_q[p] <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // Pack per-channel positions onto the bus.
  always_comb begin
    bus.pos = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      bus.pos[POS_W*p +: POS_W] = pos_q[p];
    end
  end

  assign bus.step_l = sl_q;
  assign bus.step_r = sr_q;
  assign bus.err    = err_q;
endmodule
